qspis_wb_arb: RTL and testbench

- Two-requester arbiter/sequencer that shares one Wishbone master port between register-style requesters: QSPI slave host path (r0) and a debug/bist path (r1).
- Registers every bus cycle and enforces single-outstanding, level-request / pulse-ack semantics.
- Terminates stalled slaves with a timeout error.
- Sits between the QSPI slave register front-end and the SoC Wishbone interconnect.

---
 rtl/qspis_pkg.sv | 16 +
 rtl/qspis_wb_tmo.sv | 42 ++++
 rtl/qspis_wb_arb.sv | 163 ++++++++++++++++
 tb/tb_qspis_wb_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspis_pkg.sv
// Shared definitions for the QSPI-slave Wishbone arbiter.
//   state_e   : arbiter sequencer states
//   TMO_RDATA : read data returned to a requester when its access times out
//   ADDR_PAD  : upper address byte placed above the 24-bit requester address
package qspis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] TMO_RDATA = 32'hFFFF_FFFF;
  localparam logic [7:0]  ADDR_PAD  = 8'h00;

endpackage

// File: rtl/qspis_wb_tmo.sv
// Bus-cycle timeout counter.
// Ports:
//   mclk, rst_n : clock, asynchronous active-low reset
//   i_clr       : synchronous clear (highest priority)
//   i_ld        : load i_ld_val
//   i_ld_val    : load value
//   i_en        : count enable; also qualifies the expire flag
//   o_expire    : high while enabled and the count sits at TMO_CYC-1
module qspis_wb_tmo
  import qspis_pkg::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CYC = 200
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [TMO_W-1:0] i_ld_val,
  input  logic             i_en,
  output logic             o_expire
);

  localparam logic [TMO_W-1:0] LastCnt = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/qspis_wb_arb.sv
// Two-requester Wishbone arbiter/sequencer. r0 is the QSPI slave host path, r1 the
// debug/bist path. One registered bus cycle at a time, round-robin on ties, level
// requests with single-cycle ack pulses, stalled slaves terminated with an error.
// Ports:
//   mclk, rst_n                    : clock, asynchronous active-low reset
//   rN_wr/rN_rd                    : level write/read request (write wins if both)
//   rN_addr/rN_be/rN_wdata         : byte address, byte enables, write data
//   rN_rdata/rN_ack/rN_err         : read data, completion pulse, error (with ack)
//   wbm_cyc_o/stb_o/adr_o/we_o/dat_o/sel_o : Wishbone master outputs
//   wbm_dat_i/ack_i/err_i          : Wishbone slave responses
module qspis_wb_arb
  import qspis_pkg::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_CYC = 200
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        r0_wr,
  input  logic        r0_rd,
  input  logic [23:0] r0_addr,
  input  logic [3:0]  r0_be,
  input  logic [31:0] r0_wdata,
  output logic [31:0] r0_rdata,
  output logic        r0_ack,
  output logic        r0_err,
  input  logic        r1_wr,
  input  logic        r1_rd,
  input  logic [23:0] r1_addr,
  input  logic [3:0]  r1_be,
  input  logic [31:0] r1_wdata,
  output logic [31:0] r1_rdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  state_e r_state, w_state_nxt;

  logic        w_req0, w_req1, w_any, w_sel1, w_grant;
  logic        w_hit, w_expire, w_term, w_err;
  logic [31:0] w_rdata;

  logic        r_last_gnt;  // 1: r1 was granted last, so r0 wins the next tie
  logic        r_gnt;       // requester currently owning the bus
  logic        r_cyc, r_we;
  logic [23:0] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_r0_rdata, r_r1_rdata;
  logic        r_r0_ack, r_r1_ack, r_r0_err, r_r1_err;

  assign w_req0  = r0_wr | r0_rd;
  assign w_req1  = r1_wr | r1_rd;
  assign w_any   = w_req0 | w_req1;
  // r1 wins when alone, or on a tie when r0 was served last.
  assign w_sel1  = w_req1 & (~w_req0 | ~r_last_gnt);
  assign w_grant = (r_state == IDLE) & w_any;

  assign w_hit   = wbm_ack_i | wbm_err_i;
  assign w_term  = (r_state == BUSY) & (w_hit | w_expire);
  // A termination without a slave response can only be the timeout.
  assign w_err   = wbm_err_i | ~w_hit;
  assign w_rdata = w_hit ? wbm_dat_i : TMO_RDATA;

  qspis_wb_tmo #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .i_clr   (r_state == DONE),
    .i_ld    (w_grant),
    .i_ld_val('0),
    .i_en    (r_state == BUSY),
    .o_expire(w_expire)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any)  w_state_nxt = BUSY;
      BUSY:    if (w_term) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_wdata    <= '0;
      r_r0_rdata <= '0;
      r_r1_rdata <= '0;
      r_r0_ack   <= 1'b0;
      r_r1_ack   <= 1'b0;
      r_r0_err   <= 1'b0;
      r_r1_err   <= 1'b0;
    end else begin
      r_r0_ack <= 1'b0;
      r_r1_ack <= 1'b0;
      r_r0_err <= 1'b0;
      r_r1_err <= 1'b0;
      if (w_grant) begin
        r_gnt      <= w_sel1;
        r_last_gnt <= w_sel1;
        r_cyc      <= 1'b1;
        r_we       <= w_sel1 ? r1_wr    : r0_wr;
        r_addr     <= w_sel1 ? r1_addr  : r0_addr;
        r_sel      <= w_sel1 ? r1_be    : r0_be;
        r_wdata    <= w_sel1 ? r1_wdata : r0_wdata;
      end
      if (w_term) begin
        r_cyc <= 1'b0;
        if (r_gnt) begin
          r_r1_ack <= 1'b1;
          r_r1_err <= w_err;
          if (!r_we) r_r1_rdata <= w_rdata;
        end else begin
          r_r0_ack <= 1'b1;
          r_r0_err <= w_err;
          if (!r_we) r_r0_rdata <= w_rdata;
        end
      end
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_adr_o = {ADDR_PAD, r_addr};
  assign wbm_we_o  = r_we;
  assign wbm_dat_o = r_wdata;
  assign wbm_sel_o = r_sel;

  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;
  assign r0_ack    = r_r0_ack;
  assign r1_ack    = r_r1_ack;
  assign r0_err    = r_r0_err;
  assign r1_err    = r_r1_err;

endmodule

// File: tb/tb_qspis_wb_arb.sv
// Directed bench for qspis_wb_arb: a scoreboard of expected bus cycles and requester
// completions is filled as requests are driven and drained by a negedge monitor.
module tb_qspis_wb_arb;

  localparam logic [31:0] TmoData = 32'hFFFF_FFFF;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_wr = 1'b0, r0_rd = 1'b0, r1_wr = 1'b0, r1_rd = 1'b0;
  logic [23:0] r0_addr = '0, r1_addr = '0;
  logic [3:0]  r0_be = '0, r1_be = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;

  qspis_wb_arb #(
    .TMO_W  (8),
    .TMO_CYC(200)
  ) dut (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .r0_wr    (r0_wr),
    .r0_rd    (r0_rd),
    .r0_addr  (r0_addr),
    .r0_be    (r0_be),
    .r0_wdata (r0_wdata),
    .r0_rdata (r0_rdata),
    .r0_ack   (r0_ack),
    .r0_err   (r0_err),
    .r1_wr    (r1_wr),
    .r1_rd    (r1_rd),
    .r1_addr  (r1_addr),
    .r1_be    (r1_be),
    .r1_wdata (r1_wdata),
    .r1_rdata (r1_rdata),
    .r1_ack   (r1_ack),
    .r1_err   (r1_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_we_o (wbm_we_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  rsp_t mon_r;
  bus_t mon_b;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mdl_rd [2];
  logic        mdl_last;   // 1: r1 served last

  // Slave model configuration
  int          sl_lat = 0;
  int          sl_cnt = 0;
  logic [31:0] sl_data = '0;
  logic        sl_err = 1'b0, sl_both = 1'b0, sl_mute = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wishbone slave: answers sl_lat cycles after the strobe is first seen.
  always @(posedge mclk) begin
    #1;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (wbm_cyc_o && wbm_stb_o && !sl_mute) begin
      if (sl_cnt >= sl_lat) begin
        wbm_ack_i = !sl_err || sl_both;
        wbm_err_i = sl_err;
        wbm_dat_i = sl_data;
        sl_cnt    = 0;
      end else begin
        sl_cnt++;
      end
    end else begin
      sl_cnt = 0;
    end
  end

  // Monitor: bus cycle starts and requester completions against the scoreboard.
  logic prev_cyc = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0;
  always @(negedge mclk) begin
    if (wbm_cyc_o === 1'b1 && !prev_cyc) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_cycle", 32'(bus_q.size()), 32'd1);
      end else begin
        mon_b = bus_q.pop_front();
        chk("bus_adr", wbm_adr_o, mon_b.adr);
        chk("bus_we", 32'(wbm_we_o), 32'(mon_b.we));
        chk("bus_dat", wbm_dat_o, mon_b.dat);
        chk("bus_sel", 32'(wbm_sel_o), 32'(mon_b.sel));
        chk("bus_stb", 32'(wbm_stb_o), 32'd1);
      end
    end
    if (r0_ack || r1_ack) begin
      chk("ack_onehot", 32'(r0_ack & r1_ack), 32'd0);
      if (rsp_q.size() == 0) begin
        chk("ack_unexpected", 32'(rsp_q.size()), 32'd1);
      end else begin
        mon_r = rsp_q.pop_front();
        chk("ack_id", r1_ack ? 32'd1 : 32'd0, 32'(mon_r.id));
        chk("ack_rdata", r1_ack ? r1_rdata : r0_rdata, mon_r.rdata);
        chk("ack_err", 32'(r1_ack ? r1_err : r0_err), 32'(mon_r.err));
      end
    end
    if (r0_ack) chk("ack0_single_cycle", 32'(prev_a0), 32'd0);
    if (r1_ack) chk("ack1_single_cycle", 32'(prev_a1), 32'd0);
    if (r0_err) chk("err0_without_ack", 32'(r0_ack), 32'd1);
    if (r1_err) chk("err1_without_ack", 32'(r1_ack), 32'd1);
    prev_cyc = (wbm_cyc_o === 1'b1);
    prev_a0  = (r0_ack === 1'b1);
    prev_a1  = (r1_ack === 1'b1);
  end

  task automatic expect_bus(input logic wr, input logic [23:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
    bus_t b;
    b.adr = {8'h00, addr};
    b.we  = wr;
    b.dat = wd;
    b.sel = be;
    bus_q.push_back(b);
  endtask

  task automatic expect_txn(input int id, input logic wr, input logic [23:0] addr,
                            input logic [3:0] be, input logic [31:0] wd,
                            input logic [31:0] rsp, input logic err);
    rsp_t r;
    expect_bus(wr, addr, be, wd);
    if (!wr) mdl_rd[id] = rsp;
    r.id    = id;
    r.rdata = mdl_rd[id];
    r.err   = err;
    rsp_q.push_back(r);
    mdl_last = (id == 1);
  endtask

  task automatic drive_req(input int id, input logic wr, input logic rd, input logic [23:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    if (id == 0) begin
      r0_wr = wr; r0_rd = rd; r0_addr = addr; r0_be = be; r0_wdata = wd;
    end else begin
      r1_wr = wr; r1_rd = rd; r1_addr = addr; r1_be = be; r1_wdata = wd;
    end
  endtask

  // Waits (bounded) for requester id's ack, counting bus-cycle-high cycles, then drops it.
  task automatic wait_ack(input int id, output int cyc_cnt);
    bit seen;
    seen    = 1'b0;
    cyc_cnt = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge mclk);
      if (wbm_cyc_o === 1'b1) cyc_cnt++;
      if ((id == 0 && r0_ack === 1'b1) || (id == 1 && r1_ack === 1'b1)) seen = 1'b1;
    end
    chk($sformatf("ack%0d_seen", id), 32'(seen), 32'd1);
    if (id == 0) begin
      r0_wr = 1'b0; r0_rd = 1'b0;
    end else begin
      r1_wr = 1'b0; r1_rd = 1'b0;
    end
  endtask

  task automatic next_drive();
    @(posedge mclk);
    #1;
  endtask

  // Both requesters raise the same kind of access together; order follows round robin.
  task automatic pair(input logic wr, input logic [23:0] a0, input logic [23:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] rsp);
    int first, c;
    first = mdl_last ? 0 : 1;
    if (first == 0) begin
      expect_txn(0, wr, a0, b0, d0, rsp, 1'b0);
      expect_txn(1, wr, a1, b1, d1, rsp, 1'b0);
    end else begin
      expect_txn(1, wr, a1, b1, d1, rsp, 1'b0);
      expect_txn(0, wr, a0, b0, d0, rsp, 1'b0);
    end
    drive_req(0, wr, !wr, a0, b0, d0);
    drive_req(1, wr, !wr, a1, b1, d1);
    wait_ack(first, c);
    chk("pair_first_len", 32'(c), 32'(sl_lat + 1));
    wait_ack(1 - first, c);
    chk("pair_second_len", 32'(c), 32'(sl_lat + 1));
  endtask

  initial begin
    int c;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    mdl_last  = 1'b1;

    // Reset state
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_acks", 32'({r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
    chk("rst_rdata0", r0_rdata, 32'd0);
    chk("rst_rdata1", r1_rdata, 32'd0);
    @(negedge mclk);
    rst_n = 1'b1;
    next_drive();

    // Simultaneous writes from reset: r0 then r1
    sl_lat = 0; sl_data = 32'h5555_5555;
    pair(1'b1, 24'h00_0010, 24'h00_0020, 4'hF, 4'h3, 32'h1111_1111, 32'h2222_2222, sl_data);
    next_drive();

    // r0 read with two strobe cycles
    sl_lat = 1; sl_data = 32'hCAFE_0001;
    expect_txn(0, 1'b0, 24'h00_1000, 4'hA, 32'h0, 32'hCAFE_0001, 1'b0);
    drive_req(0, 1'b0, 1'b1, 24'h00_1000, 4'hA, 32'h0);
    chk("cyc_before_sample", 32'(wbm_cyc_o), 32'd0);
    next_drive();
    chk("cyc_one_cycle_after_req", 32'(wbm_cyc_o), 32'd1);
    wait_ack(0, c);
    chk("rd_cyc_len", 32'(c), 32'd2);
    chk("r1_ack_idle", 32'(r1_ack), 32'd0);
    next_drive();

    // Next simultaneous pair alternates: r1 then r0
    sl_lat = 0;
    pair(1'b1, 24'h00_0030, 24'h00_0034, 4'h1, 4'h8, 32'h3333_3333, 32'h4444_4444, sl_data);
    next_drive();

    // r1 read terminated by err_i
    sl_err = 1'b1; sl_data = 32'hDEAD_BEEF;
    expect_txn(1, 1'b0, 24'h00_0040, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    drive_req(1, 1'b0, 1'b1, 24'h00_0040, 4'hF, 32'h0);
    wait_ack(1, c);
    next_drive();

    // r0 read with ack_i and err_i together: error, data still loaded
    sl_both = 1'b1; sl_data = 32'h0BAD_0BAD;
    expect_txn(0, 1'b0, 24'h00_0044, 4'hF, 32'h0, 32'h0BAD_0BAD, 1'b1);
    drive_req(0, 1'b0, 1'b1, 24'h00_0044, 4'hF, 32'h0);
    wait_ack(0, c);
    sl_err = 1'b0; sl_both = 1'b0;
    next_drive();

    // r0 read to a silent slave: timeout after 200 busy cycles
    sl_mute = 1'b1;
    expect_txn(0, 1'b0, 24'h00_2000, 4'hF, 32'h0, TmoData, 1'b1);
    drive_req(0, 1'b0, 1'b1, 24'h00_2000, 4'hF, 32'h0);
    wait_ack(0, c);
    chk("tmo_cyc_len", 32'(c), 32'd200);
    sl_mute = 1'b0;
    next_drive();

    // r1 served normally afterwards
    sl_lat = 2; sl_data = 32'h1234_5678;
    expect_txn(1, 1'b0, 24'h00_3000, 4'h6, 32'h0, 32'h1234_5678, 1'b0);
    drive_req(1, 1'b0, 1'b1, 24'h00_3000, 4'h6, 32'h0);
    wait_ack(1, c);
    chk("r1_after_tmo_len", 32'(c), 32'd3);
    next_drive();

    // wr=rd=1 is a write; r0_rdata keeps its previous value
    sl_lat = 0; sl_data = 32'h5555_5555;
    expect_txn(0, 1'b1, 24'hFF_FFFC, 4'hC, 32'h9999_0000, 32'h0, 1'b0);
    drive_req(0, 1'b1, 1'b1, 24'hFF_FFFC, 4'hC, 32'h9999_0000);
    wait_ack(0, c);
    chk("wr_rd_rdata_kept", r0_rdata, TmoData);
    next_drive();

    // Reset while BUSY: bus and acks drop without waiting for a clock
    sl_mute = 1'b1;
    mdl_last = 1'b0;
    expect_bus(1'b0, 24'h00_4000, 4'hF, 32'h0);
    drive_req(0, 1'b0, 1'b1, 24'h00_4000, 4'hF, 32'h0);
    repeat (4) @(negedge mclk);
    chk("busy_before_rst", 32'(wbm_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_async_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_async_ack", 32'({r0_ack, r1_ack}), 32'd0);
    chk("rst_async_rdata0", r0_rdata, 32'd0);
    drive_req(0, 1'b0, 1'b0, 24'h0, 4'h0, 32'h0);
    sl_mute   = 1'b0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    mdl_last  = 1'b1;
    @(negedge mclk);
    rst_n = 1'b1;
    next_drive();

    // After reset the tie goes to r0 again
    sl_data = 32'h7777_0000;
    pair(1'b0, 24'h00_0050, 24'h00_0060, 4'hF, 4'hF, 32'h0, 32'h0, sl_data);

    repeat (3) @(posedge mclk);
    #1;
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
